if_id_fetch_stage: RTL and testbench
====================================

Name: if_id_fetch_stage

Overview:
- Instruction-fetch stage with IF/ID pipeline register, directly upstream of control_unite.
- Holds the PC and issues requests to instruction memory over a ready handshake.
- Buffers one returned word when decode stalls, and redirects on taken branches.
- Drives opcode (instr[31:26]) straight into control_unite plus the IF/ID payload for decode.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0
PC_INC, 4, byte increment per sequential fetch

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  synchronous active-low reset
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch byte address (= pc)
imem_ready  input  1  imem_rdata valid for the current imem_addr this cycle
imem_rdata  input  32  instruction word
stall  input  1  decode cannot accept; IF/ID must hold
branch_taken  input  1  redirect PC this cycle
branch_target  input  32  redirect address; bits [1:0] forced to 0
if_id_valid  output  1  IF/ID holds a real instruction
if_id_instr  output  32  IF/ID instruction; 32'h0 (nop) when invalid
if_id_pc_plus4  output  32  address of the IF/ID instruction + PC_INC
opcode  output  6  if_id_instr[31:26], to control_unite

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - pc=RESET_PC, state=FETCH, hold_buf=0.
  - if_id_valid=0, if_id_instr=0, if_id_pc_plus4=0, opcode=0.
  - imem_req=0 while rst_n=0.
  - Reset wins over every other input, including mid-wait and mid-HOLD; any buffered word is discarded.
- imem protocol:
  - imem samples imem_addr in each cycle imem_req=1.
  - imem_ready=1 means imem_rdata belongs to that address in that same cycle.
  - A request not yet answered may be abandoned by changing the address (redirect only).
  - imem_ready is ignored when imem_req=0.
- States: FETCH, HOLD.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - ready=1, stall=0: IF/ID <= {valid=1, instr=imem_rdata, pc_plus4=pc+PC_INC}; pc<=pc+PC_INC; stay in FETCH.
  - ready=1, stall=1: hold_buf<=imem_rdata, hold_pc4<=pc+PC_INC, pc<=pc+PC_INC; go to HOLD. IF/ID unchanged.
  - ready=0, stall=0: IF/ID <= bubble (valid=0, instr=0); pc unchanged.
  - ready=0, stall=1: IF/ID unchanged; pc unchanged.
- HOLD:
  - imem_req=0.
  - stall=1: everything holds.
  - stall=0: IF/ID <= {1, hold_buf, hold_pc4}; go to FETCH (next request uses the already-advanced pc).
- Redirect (branch_taken=1, any state):
  - pc<={branch_target[31:2],2'b00}; IF/ID <= bubble even if stall=1; hold_buf discarded; state<=FETCH.
  - The same-cycle imem response, if any, is dropped.
  - imem_req/imem_addr in the redirect cycle still reflect the old pc.
  - Priority: rst_n > branch_taken > stall > imem_ready.
- Latency:
  - First imem_req rises on the first cycle after rst_n goes high.
  - IF/ID is valid on the edge that accepts an instruction with ready=1, stall=0; a zero-wait memory gives 1 instruction/cycle.
  - First fetch after a redirect is issued the following cycle (1 bubble minimum).
- Arithmetic: pc is 32-bit, mod 2^32; 32'hFFFF_FFFC + 4 wraps to 0. if_id_pc_plus4 wraps likewise.
- opcode is purely combinational from the if_id_instr register; no extra latency.
- No instruction is lost or duplicated across any stall/ready interleaving.

Test Plan:
- Reset, then imem_ready=1 constantly, rdata = 32'h1000_0000|addr → imem_addr 0,4,8,…; if_id_pc_plus4 4,8,12; opcode=6'b000100 when rdata[31:26]=000100; one instruction/cycle.
- Fetch addr 8 with ready=1 and stall=1 for 3 cycles → state HOLD, imem_req=0, IF/ID keeps the prior instruction; on stall release IF/ID=word@8, pc_plus4=12; next request addr 12.
- ready=0 for 2 cycles at addr 4, stall=0 → two bubbles (if_id_valid=0, instr=0, opcode=0), imem_addr held at 4 throughout.
- branch_taken=1, target=32'h0000_0043, while stall=1 in HOLD → buffer dropped, if_id_valid=0; next imem_addr=32'h0000_0040; same-cycle branch+stall flushes anyway.
- RESET_PC=32'hFFFF_FFF8 with ready=1 → addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; pc_plus4 wraps to 0.
- rst_n=0 pulsed mid-HOLD and mid-wait → next cycle all outputs at reset values; restart at RESET_PC with no stale buffered word delivered.

Source files
------------

// File: rtl/if_id_fetch_stage.sv
// Instruction-fetch stage: PC register, imem request/ready handshake, one-word
// stall buffer and the IF/ID pipeline register that feeds decode and control_unite.
module if_id_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic [5:0]  opcode
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] hold_buf_reg, hold_buf_next;
    logic [31:0] hold_pc4_reg, hold_pc4_next;
    logic        valid_reg, valid_next;
    logic [31:0] instr_reg, instr_next;
    logic [31:0] pc4_reg, pc4_next;

    logic [31:0] pc_inc;
    logic [31:0] target_aligned;

    assign pc_inc         = pc_reg + PC_INC;
    assign target_aligned = branch_target & ~32'h0000_0003;

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        hold_buf_next = hold_buf_reg;
        hold_pc4_next = hold_pc4_reg;
        valid_next    = valid_reg;
        instr_next    = instr_reg;
        pc4_next      = pc4_reg;

        if (branch_taken) begin
            // Redirect flushes IF/ID and the stall buffer; any same-cycle response is dropped.
            pc_next       = target_aligned;
            state_next    = FETCH;
            hold_buf_next = 32'h0;
            hold_pc4_next = 32'h0;
            valid_next    = 1'b0;
            instr_next    = 32'h0;
        end else begin
            case (state_reg)
                FETCH: begin
                    if (imem_ready) begin
                        pc_next = pc_inc;
                        if (stall) begin
                            hold_buf_next = imem_rdata;
                            hold_pc4_next = pc_inc;
                            state_next    = HOLD;
                        end else begin
                            valid_next = 1'b1;
                            instr_next = imem_rdata;
                            pc4_next   = pc_inc;
                        end
                    end else if (!stall) begin
                        valid_next = 1'b0;
                        instr_next = 32'h0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        valid_next = 1'b1;
                        instr_next = hold_buf_reg;
                        pc4_next   = hold_pc4_reg;
                        state_next = FETCH;
                    end
                end
                default: begin
                    state_next = FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= FETCH;
            pc_reg       <= RESET_PC;
            hold_buf_reg <= 32'h0;
            hold_pc4_reg <= 32'h0;
            valid_reg    <= 1'b0;
            instr_reg    <= 32'h0;
            pc4_reg      <= 32'h0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            hold_buf_reg <= hold_buf_next;
            hold_pc4_reg <= hold_pc4_next;
            valid_reg    <= valid_next;
            instr_reg    <= instr_next;
            pc4_reg      <= pc4_next;
        end
    end

    // No request while a word sits in the buffer or while reset is asserted.
    assign imem_req       = rst_n && (state_reg == FETCH);
    assign imem_addr      = pc_reg;
    assign if_id_valid    = valid_reg;
    assign if_id_instr    = instr_reg;
    assign if_id_pc_plus4 = pc4_reg;
    assign opcode         = instr_reg[31:26];

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Randomised scoreboard bench for if_id_fetch_stage, plus a directed wrap-around
// check on a second instance with RESET_PC near the top of the address space.
module tb_if_id_fetch_stage;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic [5:0]  opcode;

    logic        rst2_n = 1'b0;
    logic        ready2 = 1'b0;
    logic        stall2 = 1'b0;
    logic        br2 = 1'b0;
    logic [31:0] tgt2 = 32'h0;
    logic [31:0] rdata2;
    logic        req2;
    logic [31:0] addr2;
    logic        valid2;
    logic [31:0] instr2;
    logic [31:0] pc4_2;
    logic [5:0]  opcode2;

    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    always #5 clk = ~clk;

    if_id_fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
        .if_id_pc_plus4(if_id_pc_plus4), .opcode(opcode)
    );

    if_id_fetch_stage #(.RESET_PC(WRAP_PC)) dut2 (
        .clk(clk), .rst_n(rst2_n), .imem_req(req2), .imem_addr(addr2),
        .imem_ready(ready2), .imem_rdata(rdata2), .stall(stall2),
        .branch_taken(br2), .branch_target(tgt2),
        .if_id_valid(valid2), .if_id_instr(instr2),
        .if_id_pc_plus4(pc4_2), .opcode(opcode2)
    );

    // Simple memory for the wrap test: word = 0x1000_0000 | address.
    assign rdata2 = 32'h1000_0000 | addr2;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: program counter, "word waiting in the buffer" flag and
    // the queue of words that must still reach IF/ID, in order.
    entry_t      sb[$];
    logic [31:0] m_pc = 32'h0;
    bit          m_held = 1'b0;
    bit          exp_req = 1'b0;
    logic [31:0] exp_addr = 32'h0;
    bit          chk_en = 1'b0;
    bit          l_reset, l_bubble, l_hold, l_deliver;
    bit          prev_valid = 1'b0;
    logic [31:0] prev_instr = 32'h0;
    logic [31:0] prev_pc4 = 32'h0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_update(input bit r, input bit b, input logic [31:0] t,
                                input bit s, input bit y, input logic [31:0] d);
        bit held_before;
        entry_t e;
        held_before = m_held;
        l_reset   = !r;
        l_hold    = r && !b && s;
        l_bubble  = !r || (r && b) || (r && !b && !held_before && !y && !s);
        l_deliver = r && !b && !s && (held_before || y);
        if (!r) begin
            m_pc = 32'h0;
            m_held = 1'b0;
            sb.delete();
        end else if (b) begin
            m_pc = {t[31:2], 2'b00};
            m_held = 1'b0;
            sb.delete();
        end else if (held_before) begin
            if (!s) m_held = 1'b0;
        end else if (y) begin
            e.instr = d;
            e.pc4 = m_pc + 32'd4;
            sb.push_back(e);
            m_pc = m_pc + 32'd4;
            if (s) m_held = 1'b1;
        end
        chk_en = 1'b1;
    endtask

    // Drive one cycle of inputs, then fold the sampled inputs into the model.
    task automatic cyc(input bit r, input bit b, input logic [31:0] t,
                       input bit s, input bit y, input logic [31:0] d);
        rst_n = r; branch_taken = b; branch_target = t;
        stall = s; imem_ready = y; imem_rdata = d;
        exp_req = r && !m_held;
        exp_addr = m_pc;
        $display("cyc rst_n=%0b br=%0b tgt=%08h stall=%0b ready=%0b rdata=%08h exp_addr=%08h",
                 r, b, t, s, y, d, m_pc);
        @(posedge clk);
        #1;
        model_update(r, b, t, s, y, d);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(3) == 0) w[31:26] = 6'b000100;
        return w;
    endfunction

    // Monitor: compares DUT outputs with the model and pops the scoreboard on each delivery.
    always @(negedge clk) begin
        if (chk_en) begin
            bit is_new;
            entry_t e;
            chk(imem_req == exp_req, "imem_req", {31'h0, imem_req}, {31'h0, exp_req});
            if (exp_req && imem_req)
                chk(imem_addr == exp_addr, "imem_addr", imem_addr, exp_addr);
            if (l_bubble) begin
                chk(!if_id_valid, "bubble_valid", {31'h0, if_id_valid}, 32'h0);
                chk(if_id_instr == 32'h0, "bubble_instr", if_id_instr, 32'h0);
                chk(opcode == 6'h0, "bubble_opcode", {26'h0, opcode}, 32'h0);
            end else if (l_hold) begin
                chk(if_id_valid == prev_valid, "hold_valid", {31'h0, if_id_valid}, {31'h0, prev_valid});
                chk(if_id_instr == prev_instr, "hold_instr", if_id_instr, prev_instr);
            end
            if (l_reset)
                chk(if_id_pc_plus4 == 32'h0, "reset_pc4", if_id_pc_plus4, 32'h0);
            is_new = if_id_valid && (!prev_valid || if_id_instr != prev_instr || if_id_pc_plus4 != prev_pc4);
            if (l_deliver)
                chk(is_new, "delivery_seen", {31'h0, is_new}, 32'h1);
            if (is_new) begin
                if (sb.size() == 0) begin
                    chk(1'b0, "spurious_delivery", if_id_instr, 32'h0);
                end else begin
                    e = sb.pop_front();
                    chk(if_id_instr == e.instr, "instr", if_id_instr, e.instr);
                    chk(if_id_pc_plus4 == e.pc4, "pc_plus4", if_id_pc_plus4, e.pc4);
                    chk(opcode == e.instr[31:26], "opcode", {26'h0, opcode}, {26'h0, e.instr[31:26]});
                end
            end
            prev_valid <= if_id_valid;
            prev_instr <= if_id_instr;
            prev_pc4   <= if_id_pc_plus4;
        end
    end

    initial begin
        @(posedge clk);
        #1;
        // Zero-wait streaming with rdata = 0x1000_0000 | addr.
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 1, 32'h1000_0000 | m_pc);
        // Stall with ready at address 8 for three cycles, then release.
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 32'h1000_0000 | m_pc);
        cyc(1, 0, 0, 0, 1, 32'h1000_0000 | m_pc);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, 1, 32'h1000_0000 | m_pc);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 1, 32'h1000_0000 | m_pc);
        // Two wait cycles at address 4.
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 32'h2000_0000);
        cyc(1, 0, 0, 0, 0, 32'hDEAD_BEEF);
        cyc(1, 0, 0, 0, 0, 32'hDEAD_BEEF);
        cyc(1, 0, 0, 0, 1, 32'h2000_0004);
        // Branch while stalled in HOLD: buffer dropped, next fetch at 0x40.
        cyc(1, 0, 0, 1, 1, 32'h3000_0008);
        cyc(1, 0, 0, 1, 1, 32'hBAD0_0000);
        cyc(1, 1, 32'h0000_0043, 1, 1, 32'hBAD0_0001);
        cyc(1, 0, 0, 0, 1, 32'h3000_0040);
        cyc(1, 0, 0, 0, 1, 32'h3000_0044);
        // Reset mid-HOLD, then mid-wait.
        cyc(1, 0, 0, 1, 1, 32'h4000_0000);
        cyc(0, 0, 0, 1, 1, 32'h4000_0001);
        cyc(1, 0, 0, 0, 1, 32'h5000_0000);
        cyc(1, 0, 0, 0, 0, 32'h5000_0001);
        cyc(0, 0, 0, 0, 0, 32'h5000_0002);
        cyc(1, 0, 0, 0, 1, 32'h6000_0000);
        // Randomised interleavings.
        for (int i = 0; i < 2000; i++) begin
            bit r, b, s, y;
            r = ($urandom_range(99) != 0);
            b = ($urandom_range(99) < 5);
            s = ($urandom_range(99) < 30);
            y = ($urandom_range(99) < 70);
            cyc(r, b, $urandom, s, y, rand_word());
        end
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);
        chk(sb.size() == 0, "scoreboard_drained", sb.size(), 32'h0);
        chk_en = 1'b0;

        // Wrap-around on the second instance.
        rst2_n = 1'b0;
        ready2 = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst2_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            logic [31:0] a;
            a = WRAP_PC + 32'(4 * k);
            @(negedge clk);
            $display("wrap k=%0d addr=%08h pc4=%08h instr=%08h", k, addr2, pc4_2, instr2);
            chk(req2 == 1'b1, "wrap_req", {31'h0, req2}, 32'h1);
            chk(addr2 == a, "wrap_addr", addr2, a);
            if (k >= 1) begin
                chk(pc4_2 == a, "wrap_pc4", pc4_2, a);
                chk(instr2 == (32'h1000_0000 | (a - 32'd4)), "wrap_instr", instr2, 32'h1000_0000 | (a - 32'd4));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
